// File: rtl/gnn_input_loader_if.sv
// Stream-in and GNN-facing signal bundle for the GNN input loader.
// The loader takes the slave side; the stream source and GNN take the master side.
interface gnn_input_loader_if #(
    parameter int DW    = 5,
    parameter int NUM_X = 16,
    parameter int NUM_W = 24
);
    logic                   s_valid;
    logic signed [DW-1:0]   s_data;
    logic                   s_last;
    logic                   s_ready;
    logic                   done_i;
    logic                   in_ready;
    logic [NUM_X*DW-1:0]    x_bus;
    logic [NUM_W*DW-1:0]    w_bus;
    logic                   busy;
    logic                   frame_err;
    logic                   timeout_err;
    logic [15:0]            frame_cnt;

    modport master (
        output s_valid, s_data, s_last, done_i,
        input  s_ready, in_ready, x_bus, w_bus, busy, frame_err, timeout_err, frame_cnt
    );

    modport slave (
        input  s_valid, s_data, s_last, done_i,
        output s_ready, in_ready, x_bus, w_bus, busy, frame_err, timeout_err, frame_cnt
    );
endinterface

// File: rtl/gnn_input_loader.sv
// Assembles 40-word serial frames into a staging buffer and hands each complete
// frame to the GNN as stable x/w buses, with framing and done-timeout supervision.
module gnn_input_loader #(
    parameter int DW      = 5,
    parameter int NUM_X   = 16,
    parameter int NUM_W   = 24,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    gnn_input_loader_if.slave bus
);
    localparam int NUM_TOT = NUM_X + NUM_W;
    localparam int CW      = $clog2(NUM_TOT + 1);
    localparam int TW      = $clog2(TIMEOUT);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t              state_reg, state_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [TW-1:0]       timer_reg, timer_next;
    logic                in_ready_reg, in_ready_next;
    logic                frame_err_reg, frame_err_next;
    logic                timeout_err_reg, timeout_err_next;
    logic [15:0]         frame_cnt_reg, frame_cnt_next;
    logic [NUM_X*DW-1:0] x_reg;
    logic [NUM_W*DW-1:0] w_reg;

    logic [DW-1:0]        staging [NUM_TOT];
    logic [NUM_TOT*DW-1:0] staging_flat;

    logic s_ready;
    logic accept;
    logic last_slot;
    logic issue;

    assign s_ready   = (cnt_reg < CW'(NUM_TOT));
    assign accept    = bus.s_valid && s_ready;
    assign last_slot = (cnt_reg == CW'(NUM_TOT - 1));

    // Staging words need no reset: cnt gates what is ever copied out.
    always_ff @(posedge clk) begin
        if (accept) begin
            staging[cnt_reg] <= bus.s_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_TOT; gi++) begin : g_flat
            assign staging_flat[DW*gi +: DW] = staging[gi];
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        timer_next       = timer_reg;
        in_ready_next    = 1'b0;
        frame_err_next   = 1'b0;
        timeout_err_next = 1'b0;
        frame_cnt_next   = frame_cnt_reg;
        issue            = 1'b0;

        // An s_last that disagrees with the slot position drops the whole frame.
        if (accept) begin
            if (bus.s_last != last_slot) begin
                cnt_next       = '0;
                frame_err_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end

        case (state_reg)
            ST_IDLE: begin
                if (cnt_reg == CW'(NUM_TOT)) begin
                    issue          = 1'b1;
                    cnt_next       = '0;
                    in_ready_next  = 1'b1;
                    timer_next     = '0;
                    frame_cnt_next = frame_cnt_reg + 1'b1;
                    state_next     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // done_i is not trusted during the start pulse itself.
                if (bus.done_i && !in_ready_reg) begin
                    state_next = ST_IDLE;
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    state_next       = ST_IDLE;
                    timeout_err_next = 1'b1;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            timer_reg       <= '0;
            in_ready_reg    <= 1'b0;
            frame_err_reg   <= 1'b0;
            timeout_err_reg <= 1'b0;
            frame_cnt_reg   <= '0;
            x_reg           <= '0;
            w_reg           <= '0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            timer_reg       <= timer_next;
            in_ready_reg    <= in_ready_next;
            frame_err_reg   <= frame_err_next;
            timeout_err_reg <= timeout_err_next;
            frame_cnt_reg   <= frame_cnt_next;
            if (issue) begin
                x_reg <= staging_flat[NUM_X*DW-1:0];
                w_reg <= staging_flat[NUM_TOT*DW-1:NUM_X*DW];
            end
        end
    end

    assign bus.s_ready     = s_ready;
    assign bus.in_ready    = in_ready_reg;
    assign bus.x_bus       = x_reg;
    assign bus.w_bus       = w_reg;
    assign bus.busy        = (state_reg == ST_BUSY);
    assign bus.frame_err   = frame_err_reg;
    assign bus.timeout_err = timeout_err_reg;
    assign bus.frame_cnt   = frame_cnt_reg;
endmodule

// File: tb/tb_gnn_input_loader.sv
// Scoreboard bench for gnn_input_loader: a frame-level model queues expected
// issues, and a monitor checks every in_ready pulse and bus stability.
module tb_gnn_input_loader;
    localparam int DW      = 5;
    localparam int NUM_X   = 16;
    localparam int NUM_W   = 24;
    localparam int NUM_TOT = NUM_X + NUM_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done_man  = 1'b0;
    logic done_auto = 1'b0;
    bit   auto_en   = 1'b0;

    always #5 clk = ~clk;

    gnn_input_loader_if #(.DW(DW), .NUM_X(NUM_X), .NUM_W(NUM_W)) bus ();
    assign bus.done_i = done_man | done_auto;

    gnn_input_loader #(.DW(DW), .NUM_X(NUM_X), .NUM_W(NUM_W), .TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [NUM_X*DW-1:0] x;
        logic [NUM_W*DW-1:0] w;
        logic [15:0]         n;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mdl_words[$];
    int            mdl_frames = 0;
    int            mdl_err    = 0;

    int total = 0, bad = 0, cyc = 0;
    int issued = 0, err_seen = 0, tmo_seen = 0;
    int last_issue_cyc = 0, last_tmo_cyc = 0, last_word_cyc = 0, d_cyc = 0;
    logic [DW-1:0] fw [NUM_TOT];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Frame rule: a frame is exactly 40 words with s_last on the 40th and nowhere else.
    function automatic void model_word(input logic [DW-1:0] d, input logic l);
        exp_t e;
        if (l != (mdl_words.size() == NUM_TOT - 1)) begin
            mdl_err++;
            mdl_words.delete();
        end else begin
            mdl_words.push_back(d);
            if (mdl_words.size() == NUM_TOT) begin
                for (int i = 0; i < NUM_X; i++) e.x[DW*i +: DW] = mdl_words[i];
                for (int j = 0; j < NUM_W; j++) e.w[DW*j +: DW] = mdl_words[NUM_X + j];
                mdl_frames++;
                e.n = 16'(mdl_frames);
                exp_q.push_back(e);
                mdl_words.delete();
            end
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops the scoreboard on each start pulse, otherwise demands stable buses.
    initial begin
        logic [NUM_X*DW-1:0] held_x;
        logic [NUM_W*DW-1:0] held_w;
        logic prev_ir;
        exp_t e;
        held_x = '0; held_w = '0; prev_ir = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_x = '0; held_w = '0; prev_ir = 1'b0;
            end else begin
                if (bus.in_ready) begin
                    issued++;
                    last_issue_cyc = cyc;
                    chk("in_ready_single_cycle", 128'(prev_ir), 128'(0));
                    chk("busy_at_issue", 128'(bus.busy), 128'(1));
                    if (exp_q.size() == 0) begin
                        chk("unexpected_issue", 128'(1), 128'(0));
                    end else begin
                        e = exp_q.pop_front();
                        $display("issue #%0d cyc=%0d frame_cnt=%0d", issued, cyc, bus.frame_cnt);
                        chk("issue_x_bus", 128'(bus.x_bus), 128'(e.x));
                        chk("issue_w_bus", 128'(bus.w_bus), 128'(e.w));
                        chk("issue_frame_cnt", 128'(bus.frame_cnt), 128'(e.n));
                        held_x = e.x;
                        held_w = e.w;
                    end
                end else begin
                    chk("x_bus_hold", 128'(bus.x_bus), 128'(held_x));
                    chk("w_bus_hold", 128'(bus.w_bus), 128'(held_w));
                end
                if (bus.frame_err) err_seen++;
                if (bus.timeout_err) begin
                    tmo_seen++;
                    last_tmo_cyc = cyc;
                end
                prev_ir = bus.in_ready;
            end
        end
    end

    // Randomly-delayed GNN completion, used only in the random phase.
    initial begin
        int dly;
        dly = 5;
        forever begin
            @(negedge clk);
            if (auto_en && bus.busy && !bus.in_ready && !done_auto) begin
                if (dly == 0) begin
                    done_auto = 1'b1;
                    dly = $urandom_range(2, 20);
                end else begin
                    dly--;
                end
            end else begin
                done_auto = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
        done_man = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mdl_words.delete();
        exp_q.delete();
        mdl_frames = 0;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic l);
        int budget;
        budget = 500;
        bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = l;
        while (!bus.s_ready && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0) begin
            chk("s_ready_wait", 128'(0), 128'(1));
        end else begin
            last_word_cyc = cyc;
            model_word(d, l);
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
    endtask

    task automatic send_seq(input int n, input int last_pos, input int gap_max);
        int g;
        for (int i = 0; i < n; i++) begin
            send_word(fw[i], (i == last_pos));
            if (gap_max > 0 && i < n - 1) begin
                g = $urandom_range(0, gap_max);
                repeat (g) begin @(posedge clk); #1; end
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NUM_TOT; i++) fw[i] = DW'($urandom_range(0, 31));
    endtask

    task automatic wait_issue(input int target);
        int b;
        b = 300;
        while (issued < target && b > 0) begin
            @(negedge clk);
            #1;
            b--;
        end
        chk("wait_issue", 128'(issued >= target), 128'(1));
    endtask

    task automatic pulse_done();
        @(negedge clk); #1;
        done_man = 1'b1;
        d_cyc = cyc;
        @(negedge clk); #1;
        done_man = 1'b0;
    endtask

    initial begin
        int tgt, base_err, base_iss, base_t, icyc, b, r, len;

        // Reset state
        do_reset();
        @(negedge clk); #1;
        chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_frame_err", 128'(bus.frame_err), 128'(0));
        chk("rst_timeout_err", 128'(bus.timeout_err), 128'(0));
        chk("rst_frame_cnt", 128'(bus.frame_cnt), 128'(0));
        chk("rst_x_bus", 128'(bus.x_bus), 128'(0));
        chk("rst_w_bus", 128'(bus.w_bus), 128'(0));
        chk("rst_s_ready", 128'(bus.s_ready), 128'(1));

        // Ramp features, all -1 weights; done_i during the pulse must be ignored
        for (int i = 0; i < NUM_X; i++) fw[i] = DW'(i + 1);
        for (int i = NUM_X; i < NUM_TOT; i++) fw[i] = 5'b11111;
        tgt = issued + 1;
        send_seq(NUM_TOT, NUM_TOT - 1, 0);
        wait_issue(tgt);
        chk("t1_latency", 128'(last_issue_cyc - last_word_cyc), 128'(2));
        chk("t1_x_word0", 128'(bus.x_bus[4:0]), 128'(5'd1));
        chk("t1_x_word15", 128'(bus.x_bus[79:75]), 128'(5'b10000));
        chk("t1_w_all_ones", 128'(bus.w_bus), 128'({NUM_W{5'b11111}}));
        chk("t1_frame_cnt", 128'(bus.frame_cnt), 128'(1));
        done_man = 1'b1;
        @(negedge clk); #1;
        chk("t1_done_ignored_on_pulse", 128'(bus.busy), 128'(1));
        @(negedge clk); #1;
        chk("t1_done_clears_busy", 128'(bus.busy), 128'(0));
        done_man = 1'b0;

        // Frame B loads and stalls behind a busy GNN
        fill_random();
        tgt = issued + 1;
        send_seq(NUM_TOT, NUM_TOT - 1, 0);
        for (int i = 0; i < NUM_TOT; i++) fw[i] = 5'd3;
        send_seq(NUM_TOT, NUM_TOT - 1, 0);
        repeat (2) begin @(negedge clk); #1; end
        chk("t2_s_ready_full", 128'(bus.s_ready), 128'(0));
        chk("t2_busy_held", 128'(bus.busy), 128'(1));
        chk("t2_only_a_issued", 128'(issued), 128'(tgt));
        pulse_done();
        wait_issue(tgt + 1);
        chk("t2_latency_from_done", 128'(last_issue_cyc - d_cyc), 128'(2));
        chk("t2_x_all_threes", 128'(bus.x_bus), 128'({NUM_X{5'd3}}));
        pulse_done();

        // Early s_last
        base_err = err_seen; base_iss = issued;
        fill_random();
        send_seq(10, 9, 0);
        repeat (3) begin @(negedge clk); #1; end
        chk("t3_frame_err_once", 128'(err_seen - base_err), 128'(1));
        chk("t3_no_issue", 128'(issued), 128'(base_iss));
        chk("t3_s_ready", 128'(bus.s_ready), 128'(1));
        fill_random();
        send_seq(NUM_TOT, NUM_TOT - 1, 1);
        wait_issue(base_iss + 1);
        pulse_done();

        // Missing s_last
        base_err = err_seen; base_iss = issued;
        fill_random();
        send_seq(NUM_TOT, -1, 0);
        repeat (3) begin @(negedge clk); #1; end
        chk("t4_frame_err_once", 128'(err_seen - base_err), 128'(1));
        chk("t4_no_issue", 128'(issued), 128'(base_iss));
        chk("t4_cnt_cleared", 128'(bus.s_ready), 128'(1));
        chk("t4_idle", 128'(bus.busy), 128'(0));
        fill_random();
        send_seq(NUM_TOT, NUM_TOT - 1, 0);
        wait_issue(base_iss + 1);
        pulse_done();

        // Timeout with a pending full frame
        fill_random();
        tgt = issued + 1;
        send_seq(NUM_TOT, NUM_TOT - 1, 0);
        wait_issue(tgt);
        icyc = last_issue_cyc;
        base_t = tmo_seen;
        fill_random();
        send_seq(NUM_TOT, NUM_TOT - 1, 0);
        b = 150;
        while (tmo_seen == base_t && b > 0) begin @(negedge clk); #1; b--; end
        chk("t5_timeout_seen", 128'(tmo_seen - base_t), 128'(1));
        chk("t5_timeout_after_64", 128'(last_tmo_cyc - icyc), 128'(64));
        chk("t5_busy_cleared", 128'(bus.busy), 128'(0));
        wait_issue(tgt + 1);
        chk("t5_pending_issue_next", 128'(last_issue_cyc - last_tmo_cyc), 128'(1));
        chk("t5_timeout_single", 128'(tmo_seen - base_t), 128'(1));
        pulse_done();

        // Reset mid-frame
        base_err = err_seen;
        fill_random();
        send_seq(20, -1, 0);
        do_reset();
        @(negedge clk); #1;
        chk("t6_no_err", 128'(err_seen - base_err), 128'(0));
        chk("t6_x_zero", 128'(bus.x_bus), 128'(0));
        chk("t6_w_zero", 128'(bus.w_bus), 128'(0));
        chk("t6_frame_cnt_zero", 128'(bus.frame_cnt), 128'(0));
        chk("t6_busy_zero", 128'(bus.busy), 128'(0));
        mdl_err = err_seen;
        fill_random();
        tgt = issued + 1;
        send_seq(NUM_TOT, NUM_TOT - 1, 0);
        wait_issue(tgt);
        chk("t6_frame_cnt_one", 128'(bus.frame_cnt), 128'(1));
        pulse_done();

        // Random frames, gaps and GNN latencies
        auto_en = 1'b1;
        for (int f = 0; f < 10; f++) begin
            r = $urandom_range(0, 4);
            fill_random();
            if (r == 0) begin
                len = $urandom_range(1, NUM_TOT);
                send_seq(len, (len == NUM_TOT) ? -1 : len - 1, 2);
            end else begin
                send_seq(NUM_TOT, NUM_TOT - 1, 2);
            end
        end
        b = 800;
        while ((exp_q.size() != 0 || bus.busy) && b > 0) begin @(negedge clk); #1; b--; end
        auto_en = 1'b0;
        chk("rand_drained", 128'(exp_q.size()), 128'(0));
        chk("rand_frame_err_count", 128'(err_seen), 128'(mdl_err));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
